data_mem_arbiter: RTL and testbench

DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

---
 rtl/data_mem_arbiter_pkg.sv | 15 +
 rtl/data_mem_arbiter_rr_arbiter2.sv | 19 +
 rtl/data_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_data_mem_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared widths and FSM encoding for the data memory arbiter
package data_mem_arbiter_pkg;

  localparam int DATA_MEM_ADDR_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// rtl/data_mem_arbiter_rr_arbiter2.sv - two-way round-robin grant decision
module rr_arbiter2
  import data_mem_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic sel,
  output logic valid
);

  logic w_both;

  assign w_both = req0 & req1;
  assign valid  = req0 | req1;
  // On contention the port that did not win last time gets the grant.
  assign sel    = w_both ? ~last : (req1 ? PORT1 : PORT0);

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - two-port data memory arbiter: IDLE/ACCESS/RESP FSM and datapath registers
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req0,
  input  logic                           req1,
  input  logic                           we0,
  input  logic                           we1,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0] addr0,
  input  logic [DATA_MEM_ADDR_WIDTH-1:0] addr1,
  input  logic [31:0]                    wdata0,
  input  logic [31:0]                    wdata1,
  output logic                           gnt0,
  output logic                           gnt1,
  output logic                           rvalid0,
  output logic                           rvalid1,
  output logic [31:0]                    rdata,
  output logic                           busy,
  output logic [DATA_MEM_ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]                    mem_write_data,
  output logic                           mem_write_en,
  input  logic [31:0]                    mem_read_data
);

  state_t                         r_state;
  state_t                         w_next_state;
  logic                           r_last;
  logic                           r_port;
  logic                           r_we;
  logic                           r_gnt0;
  logic                           r_gnt1;
  logic                           r_rvalid0;
  logic                           r_rvalid1;
  logic [DATA_MEM_ADDR_WIDTH-1:0] r_mem_addr;
  logic [31:0]                    r_mem_wdata;
  logic [31:0]                    r_rdata;
  logic                           w_sel;
  logic                           w_valid;

  rr_arbiter2 u_rr (
    .req0  (req0),
    .req1  (req1),
    .last  (r_last),
    .sel   (w_sel),
    .valid (w_valid)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:   if (w_valid) w_next_state = ST_ACCESS;
      ST_ACCESS: w_next_state = r_we ? ST_IDLE : ST_RESP;
      ST_RESP:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_last      <= PORT1;
      r_port      <= PORT0;
      r_we        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_rvalid0   <= 1'b0;
      r_rvalid1   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
    end else begin
      r_gnt0    <= 1'b0;
      r_gnt1    <= 1'b0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_last      <= w_sel;
            r_port      <= w_sel;
            r_we        <= (w_sel == PORT1) ? we1 : we0;
            r_mem_addr  <= (w_sel == PORT1) ? addr1 : addr0;
            r_mem_wdata <= (w_sel == PORT1) ? wdata1 : wdata0;
            r_gnt0      <= (w_sel == PORT0);
            r_gnt1      <= (w_sel == PORT1);
          end
        end
        ST_ACCESS: begin
          if (!r_we) r_rdata <= mem_read_data;
        end
        ST_RESP: begin
          r_rvalid0 <= (r_port == PORT0);
          r_rvalid1 <= (r_port == PORT1);
        end
        default: ;
      endcase
    end
  end

  // Write enable is gated by rst so a reset landing in ACCESS suppresses the write at that edge.
  always_comb begin
    busy         = (r_state != ST_IDLE);
    mem_write_en = (r_state == ST_ACCESS) && r_we && rst;
  end

  assign gnt0           = r_gnt0;
  assign gnt1           = r_gnt1;
  assign rvalid0        = r_rvalid0;
  assign rvalid1        = r_rvalid1;
  assign rdata          = r_rdata;
  assign mem_addr       = r_mem_addr;
  assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - bench for data_mem_arbiter with transaction-level reference model
module tb_data_mem_arbiter;
  import data_mem_arbiter_pkg::*;

  localparam int AW    = DATA_MEM_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [31:0]   wdata0, wdata1;
  logic          gnt0, gnt1, rvalid0, rvalid1, busy, mem_write_en;
  logic [31:0]   rdata, mem_write_data, mem_read_data;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .req0           (req0),
    .req1           (req1),
    .we0            (we0),
    .we1            (we1),
    .addr0          (addr0),
    .addr1          (addr1),
    .wdata0         (wdata0),
    .wdata1         (wdata1),
    .gnt0           (gnt0),
    .gnt1           (gnt1),
    .rvalid0        (rvalid0),
    .rvalid1        (rvalid1),
    .rdata          (rdata),
    .busy           (busy),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write_en   (mem_write_en),
    .mem_read_data  (mem_read_data)
  );

  // data_mem stand-in: combinational read, write on the rising edge
  logic [31:0] ram  [0:DEPTH-1];
  logic [31:0] mram [0:DEPTH-1];
  assign mem_read_data = ram[mem_addr];
  always @(posedge clk) if (mem_write_en) ram[mem_addr] <= mem_write_data;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      ram[i]  = 32'h0;
      mram[i] = 32'h0;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one scheduled transaction at a time, keyed by cycle number.
  // Cycle k is the interval following rising edge k.
  int          cyc = 0;
  bit          m_ok = 1'b0;
  bit          m_last, gport, rport;
  logic [AW-1:0] m_addr;
  logic [31:0] m_wdata, m_rdata, load_val;
  int gnt_cyc = -1, we_cyc = -1, rv_cyc = -1, load_edge = -1, commit_edge = -1;
  int busy_from = -1, busy_until = -2, free_edge = 0;

  always @(posedge clk) begin
    bit p;
    bit w;
    cyc = cyc + 1;
    if (!rst) begin
      m_ok = 1'b1; m_last = 1'b1;
      m_addr = '0; m_wdata = 32'h0; m_rdata = 32'h0;
      gnt_cyc = -1; we_cyc = -1; rv_cyc = -1; load_edge = -1; commit_edge = -1;
      busy_from = -1; busy_until = -2; free_edge = cyc + 1;
    end else if (m_ok) begin
      if (commit_edge == cyc) mram[m_addr] = m_wdata;
      if (load_edge == cyc) m_rdata = load_val;
      if (cyc >= free_edge && (req0 || req1)) begin
        p       = (req0 && req1) ? !m_last : req1;
        w       = p ? we1 : we0;
        m_last  = p;
        gport   = p;
        m_addr  = p ? addr1 : addr0;
        m_wdata = p ? wdata1 : wdata0;
        gnt_cyc = cyc;
        busy_from = cyc;
        if (w) begin
          we_cyc = cyc; commit_edge = cyc + 1;
          busy_until = cyc; free_edge = cyc + 2;
        end else begin
          load_edge = cyc + 1; load_val = mram[m_addr];
          rport = p; rv_cyc = cyc + 2;
          busy_until = cyc + 1; free_edge = cyc + 3;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      chk("gnt0",    32'(gnt0),    32'(cyc == gnt_cyc && !gport));
      chk("gnt1",    32'(gnt1),    32'(cyc == gnt_cyc && gport));
      chk("rvalid0", 32'(rvalid0), 32'(cyc == rv_cyc && !rport));
      chk("rvalid1", 32'(rvalid1), 32'(cyc == rv_cyc && rport));
      chk("busy",    32'(busy),    32'(cyc >= busy_from && cyc <= busy_until));
      chk("mem_write_en",   32'(mem_write_en), 32'(cyc == we_cyc && rst));
      chk("mem_addr",       32'(mem_addr), 32'(m_addr));
      chk("mem_write_data", mem_write_data, m_wdata);
      chk("rdata",          rdata, m_rdata);
      chk("gnt_onehot",     32'(gnt0 & gnt1), 32'h0);
      chk("rvalid_onehot",  32'(rvalid0 & rvalid1), 32'h0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic single(input bit p, input bit w, input logic [AW-1:0] a, input logic [31:0] d,
                        output int glat, output int rlat, output int wen_cnt);
    glat = -1; rlat = -1; wen_cnt = 0;
    if (!p) begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
    else    begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
    for (int i = 1; i <= 20 && glat < 0; i++) begin
      tick();
      if (mem_write_en) wen_cnt++;
      if (p ? gnt1 : gnt0) glat = i;
    end
    req0 = 1'b0; req1 = 1'b0;
    for (int i = 1; i <= 6 && rlat < 0; i++) begin
      tick();
      if (mem_write_en) wen_cnt++;
      if (p ? rvalid1 : rvalid0) rlat = i;
    end
  endtask

  int ord_q[$];

  task automatic contend(input int rr0_in);
    int rr0;
    int want;
    rr0  = rr0_in;
    want = 2 + rr0_in;
    ord_q.delete();
    req0 = 1'b1; we0 = 1'b0; addr0 = AW'(3);
    req1 = 1'b1; we1 = 1'b0; addr1 = AW'(4);
    for (int i = 0; i < 60 && ord_q.size() < want; i++) begin
      tick();
      if (gnt0) begin
        ord_q.push_back(0);
        if (rr0 > 0) rr0--; else req0 = 1'b0;
      end
      if (gnt1) begin
        ord_q.push_back(1);
        req1 = 1'b0;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("contend_count", 32'(ord_q.size()), 32'(want));
    repeat (4) tick();
  endtask

  task automatic hold0(input bit w, output int gap1, output int gap2);
    int gc[$];
    req0 = 1'b1; we0 = w; addr0 = AW'(7); wdata0 = 32'hA5A5_0007;
    for (int i = 0; i < 60 && gc.size() < 3; i++) begin
      tick();
      if (gnt0) gc.push_back(i);
    end
    req0 = 1'b0;
    if (gc.size() == 3) begin gap1 = gc[1] - gc[0]; gap2 = gc[2] - gc[1]; end
    else begin gap1 = -1; gap2 = -1; end
    repeat (4) tick();
  endtask

  initial begin
    int glat, rlat, wen, g1, g2, done, got;
    bit act0, act1;
    rst = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = 32'h0; wdata1 = 32'h0;
    repeat (3) tick();
    chk("reset_busy",  32'(busy), 32'h0);
    chk("reset_rdata", rdata, 32'h0);
    rst = 1'b1;
    tick();

    single(1'b0, 1'b1, AW'(3), 32'hDEAD_BEEF, glat, rlat, wen);
    chk("wr_gnt_latency", 32'(glat), 32'd1);
    chk("wr_no_rvalid",   32'(rlat), 32'hFFFF_FFFF);
    chk("wr_en_cycles",   32'(wen),  32'd1);
    chk("wr_ram3",        ram[3],    32'hDEAD_BEEF);

    single(1'b1, 1'b0, AW'(3), 32'h0, glat, rlat, wen);
    chk("rd_gnt_latency",    32'(glat), 32'd1);
    chk("rd_rvalid_latency", 32'(rlat), 32'd2);
    chk("rd_rdata",          rdata,     32'hDEAD_BEEF);
    chk("rd_no_write",       32'(wen),  32'd0);

    rst = 1'b0; repeat (2) tick(); rst = 1'b1; tick();
    contend(1);
    chk("contend_first",  32'(ord_q[0]), 32'd0);
    chk("contend_second", 32'(ord_q[1]), 32'd1);
    chk("contend_third",  32'(ord_q[2]), 32'd0);

    hold0(1'b1, g1, g2);
    chk("b2b_wr_gap1", 32'(g1), 32'd2);
    chk("b2b_wr_gap2", 32'(g2), 32'd2);
    hold0(1'b0, g1, g2);
    chk("b2b_rd_gap1", 32'(g1), 32'd3);
    chk("b2b_rd_gap2", 32'(g2), 32'd3);

    req0 = 1'b1; we0 = 1'b1; addr0 = AW'(5); wdata0 = 32'h1234_5678;
    got = 0;
    for (int i = 0; i < 20 && got == 0; i++) begin
      tick();
      if (gnt0) got = 1;
    end
    chk("abort_gnt", 32'(got), 32'd1);
    rst = 1'b0; req0 = 1'b0;
    tick();
    chk("abort_ctl_zero", 32'({gnt0, gnt1, rvalid0, rvalid1, busy, mem_write_en}), 32'h0);
    chk("abort_addr_zero", 32'(mem_addr), 32'h0);
    chk("abort_wdata_zero", mem_write_data, 32'h0);
    chk("abort_rdata_zero", rdata, 32'h0);
    rst = 1'b1;
    tick();
    chk("abort_ram5", ram[5], 32'h0);
    contend(0);
    chk("abort_first_contend", 32'(ord_q[0]), 32'd0);

    done = 0; act0 = 1'b0; act1 = 1'b0;
    for (int c = 0; c < 20000 && done < 1000; c++) begin
      tick();
      if (act0 && gnt0) begin
        act0 = 1'b0; req0 = 1'b0; done++;
      end else if (!act0 && $urandom_range(0, 2) == 0) begin
        act0 = 1'b1; req0 = 1'b1; we0 = 1'($urandom_range(0, 1));
        addr0 = AW'($urandom_range(0, 15)); wdata0 = $urandom;
      end
      if (act1 && gnt1) begin
        act1 = 1'b0; req1 = 1'b0; done++;
      end else if (!act1 && $urandom_range(0, 2) == 0) begin
        act1 = 1'b1; req1 = 1'b1; we1 = 1'($urandom_range(0, 1));
        addr1 = AW'($urandom_range(0, 15)); wdata1 = $urandom;
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("random_grants", 32'(done), 32'd1000);
    repeat (6) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    n_err++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $fatal(1, "watchdog");
  end

endmodule
